// File: rtl/cc_microsequencer_if.sv
// Microcode fetch-loop bundle: microinstruction fields and flags in, micro-PC and status out.
// master = control-store latch side, slave = sequencer.
interface cc_microsequencer_if #(
    parameter int DATAWIDTH_BUS   = 11,
    parameter int DATAWIDTH_COND  = 3,
    parameter int DATAWIDTH_FLAGS = 4
);
    logic [DATAWIDTH_COND-1:0]  CC_MICROSEQ_Cond_InBUS;
    logic [DATAWIDTH_BUS-1:0]   CC_MICROSEQ_Jump_InBUS;
    logic [DATAWIDTH_BUS-4:0]   CC_MICROSEQ_Op_InBUS;
    logic [DATAWIDTH_FLAGS-1:0] CC_MICROSEQ_Flags_InBUS;
    logic                       CC_MICROSEQ_IR13_In;
    logic                       CC_MICROSEQ_Wait_In;
    logic                       CC_MICROSEQ_Call_In;
    logic                       CC_MICROSEQ_Return_In;
    logic [DATAWIDTH_BUS-1:0]   CC_MICROSEQ_Address_OutBUS;
    logic [1:0]                 CC_MICROSEQ_selection_OutBUS;
    logic                       CC_MICROSEQ_Valid_Out;
    logic                       CC_MICROSEQ_Error_Out;

    modport master (
        output CC_MICROSEQ_Cond_InBUS, CC_MICROSEQ_Jump_InBUS, CC_MICROSEQ_Op_InBUS,
               CC_MICROSEQ_Flags_InBUS, CC_MICROSEQ_IR13_In, CC_MICROSEQ_Wait_In,
               CC_MICROSEQ_Call_In, CC_MICROSEQ_Return_In,
        input  CC_MICROSEQ_Address_OutBUS, CC_MICROSEQ_selection_OutBUS,
               CC_MICROSEQ_Valid_Out, CC_MICROSEQ_Error_Out
    );

    modport slave (
        input  CC_MICROSEQ_Cond_InBUS, CC_MICROSEQ_Jump_InBUS, CC_MICROSEQ_Op_InBUS,
               CC_MICROSEQ_Flags_InBUS, CC_MICROSEQ_IR13_In, CC_MICROSEQ_Wait_In,
               CC_MICROSEQ_Call_In, CC_MICROSEQ_Return_In,
        output CC_MICROSEQ_Address_OutBUS, CC_MICROSEQ_selection_OutBUS,
               CC_MICROSEQ_Valid_Out, CC_MICROSEQ_Error_Out
    );
endinterface

// File: rtl/cc_microsequencer.sv
// Micro-PC sequencer (next/jump/decode/return), one registered stage; Wait freezes it in HOLD.
// Optional return stack built when CC_MICROSEQ_RETURN_STACK_EN is defined.
module cc_microsequencer #(
    parameter int DATAWIDTH_BUS   = 11,
    parameter int DATAWIDTH_COND  = 3,
    parameter int DATAWIDTH_FLAGS = 4,
    parameter int STACK_DEPTH     = 4
) (
    input  logic               CC_MICROSEQ_CLOCK_50,
    input  logic               CC_MICROSEQ_RESET_InLow,
    cc_microsequencer_if.slave bus
);
    localparam int BW = DATAWIDTH_BUS;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    localparam logic [1:0] SEL_NEXT   = 2'b00;
    localparam logic [1:0] SEL_JUMP   = 2'b01;
    localparam logic [1:0] SEL_DECODE = 2'b10;
    localparam logic [1:0] SEL_RETURN = 2'b11;

    logic [1:0]    state_q, state_d;
    logic [BW-1:0] addr_q, addr_d;
    logic [1:0]    sel_q, sel_d;
    logic          valid_q, valid_d;

    logic [BW-1:0] addr_inc;
    logic          taken;
    logic          ret_req, call_req, stack_empty, stack_full;
    logic [BW-1:0] stack_top;
    logic          push, pop, stack_err;

    assign addr_inc = addr_q + BW'(1);

    // Flag bus is {n,z,v,c}
    always_comb begin
        taken = 1'b0;
        case (bus.CC_MICROSEQ_Cond_InBUS)
            3'd1:    taken = bus.CC_MICROSEQ_Flags_InBUS[3];
            3'd2:    taken = bus.CC_MICROSEQ_Flags_InBUS[2];
            3'd3:    taken = bus.CC_MICROSEQ_Flags_InBUS[1];
            3'd4:    taken = bus.CC_MICROSEQ_Flags_InBUS[0];
            3'd5:    taken = bus.CC_MICROSEQ_IR13_In;
            3'd6:    taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        sel_d     = sel_q;
        valid_d   = valid_q;
        push      = 1'b0;
        pop       = 1'b0;
        stack_err = 1'b0;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_RUN;
                valid_d = 1'b1;
            end
            ST_RUN: begin
                if (bus.CC_MICROSEQ_Wait_In) begin
                    state_d = ST_HOLD;
                    valid_d = 1'b0;
                end else begin
                    valid_d = 1'b1;
                    if (ret_req && !stack_empty) begin
                        addr_d = stack_top;
                        sel_d  = SEL_RETURN;
                        pop    = 1'b1;
                    end else if (ret_req) begin
                        addr_d    = addr_inc;
                        sel_d     = SEL_NEXT;
                        stack_err = 1'b1;
                    end else if (bus.CC_MICROSEQ_Cond_InBUS == 3'd7) begin
                        addr_d = {1'b1, bus.CC_MICROSEQ_Op_InBUS, 2'b00};
                        sel_d  = SEL_DECODE;
                    end else if (taken) begin
                        addr_d = bus.CC_MICROSEQ_Jump_InBUS;
                        sel_d  = SEL_JUMP;
                        // A full stack drops the push but the jump still goes ahead
                        if (call_req) begin
                            push      = !stack_full;
                            stack_err = stack_full;
                        end
                    end else begin
                        addr_d = addr_inc;
                        sel_d  = SEL_NEXT;
                    end
                end
            end
            ST_HOLD: begin
                // The frozen microinstruction is re-presented; its COND is acted on next edge
                if (!bus.CC_MICROSEQ_Wait_In) begin
                    state_d = ST_RUN;
                    valid_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CC_MICROSEQ_CLOCK_50 or negedge CC_MICROSEQ_RESET_InLow) begin
        if (!CC_MICROSEQ_RESET_InLow) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            sel_q   <= SEL_NEXT;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
        end
    end

`ifdef CC_MICROSEQ_RETURN_STACK_EN
    localparam int SP_W = $clog2(STACK_DEPTH) + 1;

    logic [SP_W-1:0] sp_q, sp_d;
    logic [BW-1:0]   stack_q [STACK_DEPTH];
    logic [BW-1:0]   stack_d [STACK_DEPTH];
    logic            error_q, error_d;
    logic [SP_W-2:0] top_idx;

    // sp counts entries; the top lives at sp-1
    assign top_idx     = sp_q[SP_W-2:0] - (SP_W-1)'(1);
    assign ret_req     = bus.CC_MICROSEQ_Return_In;
    assign call_req    = bus.CC_MICROSEQ_Call_In;
    assign stack_empty = (sp_q == '0);
    assign stack_full  = (sp_q == SP_W'(STACK_DEPTH));
    assign stack_top   = stack_q[top_idx];

    always_comb begin
        sp_d    = sp_q;
        stack_d = stack_q;
        error_d = error_q;
        if (push) begin
            stack_d[sp_q[SP_W-2:0]] = addr_inc;
            sp_d                    = sp_q + SP_W'(1);
        end
        if (pop) begin
            sp_d = sp_q - SP_W'(1);
        end
        if (stack_err) begin
            error_d = 1'b1;
        end
    end

    always_ff @(posedge CC_MICROSEQ_CLOCK_50 or negedge CC_MICROSEQ_RESET_InLow) begin
        if (!CC_MICROSEQ_RESET_InLow) begin
            sp_q    <= '0;
            error_q <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_q[i] <= '0;
            end
        end else begin
            sp_q    <= sp_d;
            error_q <= error_d;
            stack_q <= stack_d;
        end
    end

    assign bus.CC_MICROSEQ_Error_Out = error_q;
`else
    localparam int unused_stack_depth = STACK_DEPTH;
    logic unused_stack_sigs;

    assign ret_req     = 1'b0;
    assign call_req    = 1'b0;
    assign stack_empty = 1'b1;
    assign stack_full  = 1'b0;
    assign stack_top   = '0;
    assign unused_stack_sigs = ^{bus.CC_MICROSEQ_Call_In, bus.CC_MICROSEQ_Return_In,
                                 push, pop, stack_err};

    assign bus.CC_MICROSEQ_Error_Out = 1'b0;
`endif

    assign bus.CC_MICROSEQ_Address_OutBUS   = addr_q;
    assign bus.CC_MICROSEQ_selection_OutBUS = sel_q;
    assign bus.CC_MICROSEQ_Valid_Out        = valid_q;
endmodule

// File: tb/tb_cc_microsequencer.sv
// Scoreboard bench for cc_microsequencer: directed test-plan sequences then randomized traffic.
// Expectations come from a queue-based reference model; a monitor compares every cycle.
module tb_cc_microsequencer;
    localparam int DEPTH = 4;
`ifdef CC_MICROSEQ_RETURN_STACK_EN
    localparam bit HAS_STACK = 1'b1;
`else
    localparam bit HAS_STACK = 1'b0;
`endif
    localparam int MP_IDLE = 0;
    localparam int MP_RUN  = 1;
    localparam int MP_HOLD = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    cc_microsequencer_if u_if ();

    cc_microsequencer dut (
        .CC_MICROSEQ_CLOCK_50   (clk),
        .CC_MICROSEQ_RESET_InLow(rst_n),
        .bus                    (u_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  cond;
        logic [10:0] jump;
        logic [7:0]  op;
        logic [3:0]  flags;
        logic        ir13;
        logic        wt;
        logic        call;
        logic        ret;
    } stim_t;

    typedef struct {
        logic [10:0] addr;
        logic [1:0]  sel;
        logic        vld;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model state
    int          m_phase;
    logic [10:0] m_addr;
    logic [1:0]  m_sel;
    logic        m_vld;
    logic        m_err;
    logic [10:0] m_stack[$];

    function automatic void model_reset();
        m_phase = MP_IDLE;
        m_addr  = 11'd0;
        m_sel   = 2'b00;
        m_vld   = 1'b0;
        m_err   = 1'b0;
        m_stack.delete();
    endfunction

    function automatic bit cond_taken(stim_t s);
        case (s.cond)
            3'd1:    return s.flags[3];
            3'd2:    return s.flags[2];
            3'd3:    return s.flags[1];
            3'd4:    return s.flags[0];
            3'd5:    return s.ir13;
            3'd6:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic void model_edge(stim_t s);
        logic [10:0] nxt;
        nxt = 11'((int'(m_addr) + 1) % 2048);
        if (m_phase == MP_IDLE) begin
            m_phase = MP_RUN;
            m_vld   = 1'b1;
        end else if (m_phase == MP_HOLD) begin
            if (!s.wt) begin
                m_phase = MP_RUN;
                m_vld   = 1'b1;
            end
        end else if (s.wt) begin
            m_phase = MP_HOLD;
            m_vld   = 1'b0;
        end else begin
            m_vld = 1'b1;
            if (HAS_STACK && s.ret) begin
                if (m_stack.size() > 0) begin
                    m_addr = m_stack.pop_back();
                    m_sel  = 2'b11;
                end else begin
                    m_addr = nxt;
                    m_sel  = 2'b00;
                    m_err  = 1'b1;
                end
            end else if (s.cond == 3'd7) begin
                m_addr = 11'(1024 + int'(s.op) * 4);
                m_sel  = 2'b10;
            end else if (cond_taken(s)) begin
                if (HAS_STACK && s.call) begin
                    if (m_stack.size() >= DEPTH) m_err = 1'b1;
                    else m_stack.push_back(nxt);
                end
                m_addr = s.jump;
                m_sel  = 2'b01;
            end else begin
                m_addr = nxt;
                m_sel  = 2'b00;
            end
        end
    endfunction

    function automatic void push_exp();
        exp_t e;
        e.addr = m_addr;
        e.sel  = m_sel;
        e.vld  = m_vld;
        e.err  = m_err;
        exp_q.push_back(e);
    endfunction

    function automatic stim_t mk(logic [2:0] cond, logic [10:0] jump, logic [7:0] op,
                                 logic [3:0] flags, logic wt, logic call, logic ret);
        stim_t s;
        s.cond  = cond;
        s.jump  = jump;
        s.op    = op;
        s.flags = flags;
        s.ir13  = 1'b0;
        s.wt    = wt;
        s.call  = call;
        s.ret   = ret;
        return s;
    endfunction

    function automatic stim_t rnd_stim();
        stim_t s;
        s.cond  = 3'($urandom_range(0, 7));
        s.jump  = 11'($urandom);
        s.op    = 8'($urandom);
        s.flags = 4'($urandom);
        s.ir13  = 1'($urandom);
        s.wt    = ($urandom_range(0, 4) == 0);
        s.call  = ($urandom_range(0, 2) == 0);
        s.ret   = ($urandom_range(0, 5) == 0);
        return s;
    endfunction

    task automatic drive(stim_t s);
        u_if.CC_MICROSEQ_Cond_InBUS  = s.cond;
        u_if.CC_MICROSEQ_Jump_InBUS  = s.jump;
        u_if.CC_MICROSEQ_Op_InBUS    = s.op;
        u_if.CC_MICROSEQ_Flags_InBUS = s.flags;
        u_if.CC_MICROSEQ_IR13_In     = s.ir13;
        u_if.CC_MICROSEQ_Wait_In     = s.wt;
        u_if.CC_MICROSEQ_Call_In     = s.call;
        u_if.CC_MICROSEQ_Return_In   = s.ret;
    endtask

    // One clock of stimulus; the expectation is for the following rising edge
    task automatic issue(stim_t s, logic rst_lvl);
        @(negedge clk);
        rst_n = rst_lvl;
        drive(s);
        if (!rst_lvl) model_reset();
        else model_edge(s);
        push_exp();
    endtask

    // Reset dropped mid-cycle: one check right away, one at the edge while held
    task automatic async_reset(stim_t s);
        @(negedge clk);
        drive(s);
        #2;
        model_reset();
        push_exp();
        push_exp();
        rst_n = 1'b0;
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, req, $time);
        end
    endtask

    // Monitor: compares outputs after every edge and every reset assertion
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or negedge rst_n);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("address",   32'(u_if.CC_MICROSEQ_Address_OutBUS),   32'(e.addr));
                check("selection", 32'(u_if.CC_MICROSEQ_selection_OutBUS), 32'(e.sel));
                check("valid",     32'(u_if.CC_MICROSEQ_Valid_Out),        32'(e.vld));
                check("error",     32'(u_if.CC_MICROSEQ_Error_Out),        32'(e.err));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d expectations pending", exp_q.size());
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        drive(mk(3'd0, 11'd0, 8'd0, 4'd0, 1'b0, 1'b0, 1'b0));
        issue(mk(3'd0, 11'd0, 8'd0, 4'd0, 1'b0, 1'b0, 1'b0), 1'b0);
        issue(mk(3'd0, 11'd0, 8'd0, 4'd0, 1'b0, 1'b0, 1'b0), 1'b0);

        // Reset release and sequential flow: 0,0,1,2,3
        repeat (4) issue(mk(3'd0, 11'd0, 8'd0, 4'd0, 1'b0, 1'b0, 1'b0), 1'b1);
        // Branch on z taken / not taken
        issue(mk(3'd6, 11'h005, 8'd0, 4'b0000, 1'b0, 1'b0, 1'b0), 1'b1);
        issue(mk(3'd2, 11'h040, 8'd0, 4'b0100, 1'b0, 1'b0, 1'b0), 1'b1);
        issue(mk(3'd6, 11'h005, 8'd0, 4'b0000, 1'b0, 1'b0, 1'b0), 1'b1);
        issue(mk(3'd2, 11'h040, 8'd0, 4'b1011, 1'b0, 1'b0, 1'b0), 1'b1);
        // Decode dispatch and address wrap
        issue(mk(3'd7, 11'h000, 8'hA5, 4'b0000, 1'b0, 1'b0, 1'b0), 1'b1);
        issue(mk(3'd6, 11'h7FF, 8'd0, 4'b0000, 1'b0, 1'b0, 1'b0), 1'b1);
        issue(mk(3'd0, 11'h000, 8'd0, 4'b0000, 1'b0, 1'b0, 1'b0), 1'b1);
        // Wait freeze at 0x010, with noisy inputs while held
        issue(mk(3'd6, 11'h010, 8'd0, 4'b0000, 1'b0, 1'b0, 1'b0), 1'b1);
        repeat (3) issue(mk(3'd6, 11'h555, 8'd0, 4'b1111, 1'b1, 1'b1, 1'b1), 1'b1);
        issue(mk(3'd0, 11'h000, 8'd0, 4'b0000, 1'b0, 1'b0, 1'b0), 1'b1);
        issue(mk(3'd0, 11'h000, 8'd0, 4'b0000, 1'b0, 1'b0, 1'b0), 1'b1);
        // Call from 0x020 to 0x100, then return
        issue(mk(3'd6, 11'h020, 8'd0, 4'b0000, 1'b0, 1'b0, 1'b0), 1'b1);
        issue(mk(3'd6, 11'h100, 8'd0, 4'b0000, 1'b0, 1'b1, 1'b0), 1'b1);
        issue(mk(3'd0, 11'h000, 8'd0, 4'b0000, 1'b0, 1'b0, 1'b1), 1'b1);
        // Not-taken call is ignored; call+return together pops only
        issue(mk(3'd1, 11'h300, 8'd0, 4'b0000, 1'b0, 1'b1, 1'b0), 1'b1);
        // Five nested calls overflow, then drain and underflow
        for (int i = 0; i < 5; i++)
            issue(mk(3'd6, 11'(32'h200 + i * 16), 8'd0, 4'b0000, 1'b0, 1'b1, 1'b0), 1'b1);
        issue(mk(3'd6, 11'h123, 8'd0, 4'b0000, 1'b0, 1'b1, 1'b1), 1'b1);
        repeat (4) issue(mk(3'd0, 11'h000, 8'd0, 4'b0000, 1'b0, 1'b0, 1'b1), 1'b1);
        // Two entries on the stack at 0x3FF, reset mid-run, then return underflows
        issue(mk(3'd6, 11'h3FE, 8'd0, 4'b0000, 1'b0, 1'b1, 1'b0), 1'b1);
        issue(mk(3'd6, 11'h3FF, 8'd0, 4'b0000, 1'b0, 1'b1, 1'b0), 1'b1);
        async_reset(mk(3'd0, 11'h000, 8'd0, 4'b0000, 1'b1, 1'b0, 1'b0));
        issue(mk(3'd0, 11'h000, 8'd0, 4'b0000, 1'b1, 1'b0, 1'b1), 1'b1);
        issue(mk(3'd0, 11'h000, 8'd0, 4'b0000, 1'b0, 1'b0, 1'b1), 1'b1);
        issue(mk(3'd0, 11'h000, 8'd0, 4'b0000, 1'b0, 1'b0, 1'b0), 1'b1);

        // Randomized traffic with occasional mid-run resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) async_reset(rnd_stim());
            else issue(rnd_stim(), 1'b1);
        end

        repeat (2) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
